branch_predictor: RTL and testbench
===================================

# branch_predictor

Parametrised dynamic branch predictor with branch target buffer (BTB), replacing the implicit always-not-taken policy of the 5-stage RV32 pipeline. It sits beside the PC register in IF:
- Each cycle it returns a same-cycle prediction (taken flag plus target) for the fetch PC.
- It is trained by resolved branches and jumps from the MEM stage.
- Per-entry state is a valid bit, a tag, a target and an N-bit saturating counter.

## Interface
Parameters:
- XLEN, 32, address/target width
- ENTRIES, 16, BTB entries; power of two, 2..256
- COUNTER_BITS, 2, saturating counter width, 1..4

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- lookup_pc  in  XLEN  PC currently being fetched
- predict_hit  out  1  valid entry with matching tag found
- predict_taken  out  1  predictor says redirect fetch
- predict_target  out  XLEN  predicted target; 0 when predict_hit=0
- update_valid  in  1  resolved control-flow instruction in MEM this cycle
- update_pc  in  XLEN  PC of the resolved instruction
- update_taken  in  1  actual outcome
- update_target  in  XLEN  actual target
- update_is_jump  in  1  unconditional jal
- update_is_jalr  in  1  jalr; ignored for training
- update_mispredict  in  1  pipeline flushed for this instruction (statistics only)
- flush  in  1  invalidate all entries
- stat_branches  out  32  trained updates counted
- stat_mispredicts  out  32  mispredicts counted

## Operation
- Index is pc[IDX+1:2] with IDX = log2(ENTRIES). Tag is pc[XLEN-1:IDX+2]. Bits [1:0] are ignored.
- Lookup is combinational from registered state:
  - predict_hit = valid[idx] && tag[idx]==lookup tag.
  - predict_taken = predict_hit && counter MSB.
  - predict_target = predict_hit ? target[idx] : 0.
- Update occurs on the clock edge when update_valid=1 and update_is_jalr=0:
  - Hit, update_is_jump=1: counter set to max, target written.
  - Hit, conditional: counter incremented (saturating at 2^CB-1) if taken, else decremented (saturating at 0). Target is written only if taken.
  - Miss, taken (or jump): allocate (overwrite, no replacement policy). Write valid=1, tag and target. Counter = max for a jump, otherwise weakly-taken (2^(CB-1)).
  - Miss, not taken: no state change.
- An update with update_is_jalr=1 changes no table state. It is still counted in statistics.
- flush: all valid bits cleared at the next edge. flush and an update in the same cycle: flush wins and the update is discarded.
- Targets, tags and counters are not reset; only valid bits are reset.

## Timing
- Prediction latency is 0 cycles (combinational on lookup_pc).
- Update becomes visible to lookup the cycle after the edge. There is no bypass: a same-cycle lookup and update to the same index returns the pre-update entry.
- Reset state: all valid=0, so predict_hit=0, predict_taken=0, predict_target=0. Statistics are 0.
- rst asserted mid-operation: every state listed above returns to its reset value at that edge, and concurrent updates are discarded.
- Counter arithmetic is unsigned and width COUNTER_BITS; it never wraps.

## Configuration
- BP_STATS_EN defined:
  - stat_branches increments on every update_valid, excluding cycles with rst or flush.
  - stat_mispredicts increments when update_valid && update_mispredict.
  - Both saturate at 0xFFFFFFFF and are cleared only by rst, not by flush.
- BP_STATS_EN undefined: both outputs are tied to 0 and no counter flops are built.

## Structure
- Add to the shared defines/package:
  - BTB entry field layout.
  - Counter init constants (weak-taken, strong-taken).
  - Index/tag slicing macros derived from ENTRIES.
- Sub-module sat_counter (parametrised width): inputs cur, inc, dec, set_max; output next.
- Table storage is a register array, written from a single process.

## Test plan
Defaults: ENTRIES=16, CB=2.
- Reset, then lookup_pc=0x40 → hit=0, taken=0, target=0x0.
- Conditional update, pc=0x40, taken=1, target=0x100; next cycle lookup 0x40 → hit=1, taken=1 (counter 2'b10), target=0x100.
- Two further not-taken updates at 0x40 → after the first, counter 01 and taken=0; after the second, counter 00. A third not-taken update stays at 00.
- Jump update, pc=0x80, target=0x200; then lookup 0x80 → counter 11, taken=1. Lookup 0x4080 (same index, tag differs) → hit=0. Updating 0x4080 taken evicts the entry, after which 0x80 misses.
- Same cycle: flush=1 and update pc=0x40 taken → next cycle 0x40 misses. Same-cycle lookup/update at 0x40 returns the old entry.
- BP_STATS_EN: 5 updates, 2 with mispredict=1 → stat_branches=5, stat_mispredicts=2. flush leaves both unchanged; rst clears both.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared types and helpers for the BTB-based branch predictor.
// Optional statistics counters are enabled with the BP_STATS_EN macro.
package branch_predictor_pkg;

    // Per-entry BTB fields (held as parallel arrays in the top):
    //   valid  : 1 bit, the only field cleared by reset/flush
    //   tag    : pc[XLEN-1:IDX+2]
    //   target : XLEN bits
    //   ctr    : COUNTER_BITS saturating direction counter

    // Which fields an accepted update writes this cycle
    typedef struct packed {
        logic set_valid;
        logic wr_tag;
        logic wr_target;
        logic wr_ctr;
    } btb_wr_t;

    // Index width derived from ENTRIES: index is pc[IDX+1:2]
    function automatic int unsigned idx_bits(input int unsigned entries);
        return $clog2(entries);
    endfunction

    // Tag width: everything above the index and the ignored byte-offset bits
    function automatic int unsigned tag_bits(input int unsigned xlen, input int unsigned entries);
        return xlen - $clog2(entries) - 2;
    endfunction

    // Strongly-taken counter value (all ones)
    function automatic int unsigned ctr_strong(input int unsigned cb);
        return (1 << cb) - 1;
    endfunction

    // Weakly-taken counter value (MSB only)
    function automatic int unsigned ctr_weak(input int unsigned cb);
        return 1 << (cb - 1);
    endfunction

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// Saturating up/down counter next-state logic; set_max has priority over inc/dec.
module branch_predictor_sat_counter #(
    parameter int unsigned WIDTH = 2
) (
    input  logic [WIDTH-1:0] cur,
    input  logic             inc,
    input  logic             dec,
    input  logic             set_max,
    output logic [WIDTH-1:0] next
);

    // Next value: force to max, or step once and clamp at either end
    always_comb begin
        next = cur;
        if (set_max) begin
            next = '1;
        end else if (inc) begin
            if (cur != '1) next = cur + WIDTH'(1);
        end else if (dec) begin
            if (cur != '0) next = cur - WIDTH'(1);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor with BTB: same-cycle lookup, trained from MEM.
// Define BP_STATS_EN to build the branch/mispredict statistics counters.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned ENTRIES      = 16,
    parameter int unsigned COUNTER_BITS = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            predict_hit,
    output logic            predict_taken,
    output logic [XLEN-1:0] predict_target,
    input  logic            update_valid,
    input  logic [XLEN-1:0] update_pc,
    input  logic            update_taken,
    input  logic [XLEN-1:0] update_target,
    input  logic            update_is_jump,
    input  logic            update_is_jalr,
    input  logic            update_mispredict,
    input  logic            flush,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
);

    localparam int unsigned IdxW = idx_bits(ENTRIES);
    localparam int unsigned TagW = tag_bits(XLEN, ENTRIES);
    localparam logic [COUNTER_BITS-1:0] CtrStrong = COUNTER_BITS'(ctr_strong(COUNTER_BITS));
    localparam logic [COUNTER_BITS-1:0] CtrWeak   = COUNTER_BITS'(ctr_weak(COUNTER_BITS));

    logic [ENTRIES-1:0]      valid_q, valid_d;
    logic [TagW-1:0]         tag_q    [ENTRIES];
    logic [XLEN-1:0]         target_q [ENTRIES];
    logic [COUNTER_BITS-1:0] ctr_q    [ENTRIES];

    logic [IdxW-1:0]         lk_idx, upd_idx;
    logic [TagW-1:0]         lk_tag, upd_tag;
    logic                    upd_hit, upd_redirect, upd_en;
    logic [COUNTER_BITS-1:0] ctr_next, ctr_d;
    btb_wr_t                 wr;

    // Byte-offset bits never take part in indexing or tagging
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc[1:0], update_pc[1:0]};

    assign lk_idx  = lookup_pc[IdxW+1:2];
    assign lk_tag  = lookup_pc[XLEN-1:IdxW+2];
    assign upd_idx = update_pc[IdxW+1:2];
    assign upd_tag = update_pc[XLEN-1:IdxW+2];

    // Combinational prediction from registered state (no update bypass)
    always_comb begin
        predict_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        predict_taken  = predict_hit && ctr_q[lk_idx][COUNTER_BITS-1];
        predict_target = predict_hit ? target_q[lk_idx] : '0;
    end

    assign upd_hit      = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign upd_redirect = update_taken || update_is_jump;
    assign upd_en       = update_valid && !update_is_jalr && !flush;

    branch_predictor_sat_counter #(
        .WIDTH(COUNTER_BITS)
    ) u_sat_counter (
        .cur    (ctr_q[upd_idx]),
        .inc    (update_taken && !update_is_jump),
        .dec    (!update_taken && !update_is_jump),
        .set_max(update_is_jump),
        .next   (ctr_next)
    );

    // Decide which fields of the indexed entry to write; flush beats any update
    always_comb begin
        valid_d = valid_q;
        wr      = '0;
        ctr_d   = ctr_next;
        if (flush) begin
            valid_d = '0;
        end else if (upd_en) begin
            if (upd_hit) begin
                wr.wr_ctr    = 1'b1;
                wr.wr_target = upd_redirect;
            end else if (upd_redirect) begin
                wr.set_valid     = 1'b1;
                wr.wr_tag        = 1'b1;
                wr.wr_target     = 1'b1;
                wr.wr_ctr        = 1'b1;
                valid_d[upd_idx] = 1'b1;
                ctr_d            = update_is_jump ? CtrStrong : CtrWeak;
            end
        end
    end

    // Table storage; only valid bits are reset, payload fields are left as-is
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
            if (wr.wr_tag)    tag_q[upd_idx]    <= upd_tag;
            if (wr.wr_target) target_q[upd_idx] <= update_target;
            if (wr.wr_ctr)    ctr_q[upd_idx]    <= ctr_d;
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] branches_q, branches_d;
    logic [31:0] mispredicts_q, mispredicts_d;

    // Saturating statistics; flush does not clear them
    always_comb begin
        branches_d    = branches_q;
        mispredicts_d = mispredicts_q;
        if (update_valid && !flush && (branches_q != '1)) begin
            branches_d = branches_q + 32'd1;
        end
        if (update_valid && update_mispredict && (mispredicts_q != '1)) begin
            mispredicts_d = mispredicts_q + 32'd1;
        end
    end

    // Statistics registers
    always_ff @(posedge clk) begin
        if (rst) begin
            branches_q    <= '0;
            mispredicts_q <= '0;
        end else begin
            branches_q    <= branches_d;
            mispredicts_q <= mispredicts_d;
        end
    end

    assign stat_branches    = branches_q;
    assign stat_mispredicts = mispredicts_q;
`else
    logic unused_mispredict;
    assign unused_mispredict = update_mispredict;
    assign stat_branches     = '0;
    assign stat_mispredicts  = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Table-driven self-checking bench for branch_predictor (ENTRIES=16, CB=2).
// Stat expectations follow BP_STATS_EN; without it the stat outputs must read 0.
module tb_branch_predictor;

`ifdef BP_STATS_EN
    localparam bit StatsEn = 1'b1;
`else
    localparam bit StatsEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] lookup_pc = '0;
    logic        predict_hit, predict_taken;
    logic [31:0] predict_target;
    logic        update_valid = 1'b0;
    logic [31:0] update_pc = '0;
    logic        update_taken = 1'b0;
    logic [31:0] update_target = '0;
    logic        update_is_jump = 1'b0;
    logic        update_is_jalr = 1'b0;
    logic        update_mispredict = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] stat_branches, stat_mispredicts;

    int tests = 0;
    int fails = 0;
    int exp_br = 0;
    int exp_mis = 0;

    always #5 clk = ~clk;

    branch_predictor #(
        .XLEN(32),
        .ENTRIES(16),
        .COUNTER_BITS(2)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .lookup_pc        (lookup_pc),
        .predict_hit      (predict_hit),
        .predict_taken    (predict_taken),
        .predict_target   (predict_target),
        .update_valid     (update_valid),
        .update_pc        (update_pc),
        .update_taken     (update_taken),
        .update_target    (update_target),
        .update_is_jump   (update_is_jump),
        .update_is_jalr   (update_is_jalr),
        .update_mispredict(update_mispredict),
        .flush            (flush),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    // Inputs for this cycle; expected outputs are the state before this cycle's edge
    typedef struct {
        bit          upd;
        logic [31:0] pc;
        bit          taken;
        logic [31:0] tgt;
        bit          jump;
        bit          jalr;
        bit          mis;
        bit          flush;
        logic [31:0] lk;
        bit          e_hit;
        bit          e_taken;
        logic [31:0] e_tgt;
    } vec_t;

    localparam int NVec = 31;
    vec_t vecs[NVec];

    function automatic vec_t mk(bit upd, logic [31:0] pc, bit taken, logic [31:0] tgt,
                                bit jump, bit jalr, bit mis, bit fl, logic [31:0] lk,
                                bit e_hit, bit e_taken, logic [31:0] e_tgt);
        vec_t v;
        v.upd = upd; v.pc = pc; v.taken = taken; v.tgt = tgt; v.jump = jump;
        v.jalr = jalr; v.mis = mis; v.flush = fl; v.lk = lk;
        v.e_hit = e_hit; v.e_taken = e_taken; v.e_tgt = e_tgt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_lookup(input string name, input bit eh, input bit et,
                                input logic [31:0] etgt);
        check({name, "_hit"}, {31'd0, predict_hit}, {31'd0, eh});
        check({name, "_taken"}, {31'd0, predict_taken}, {31'd0, et});
        check({name, "_target"}, predict_target, etgt);
    endtask

    task automatic idle_inputs();
        update_valid = 1'b0; update_pc = '0; update_taken = 1'b0; update_target = '0;
        update_is_jump = 1'b0; update_is_jalr = 1'b0; update_mispredict = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        //             upd pc        tk tgt       jmp jr mis fl lk         hit tk tgt
        vecs[0]  = mk(0, 32'h0,    0, 32'h0,   0, 0, 0, 0, 32'h40,   0, 0, 32'h0);
        vecs[1]  = mk(1, 32'h40,   1, 32'h100, 0, 0, 0, 0, 32'h40,   0, 0, 32'h0);
        vecs[2]  = mk(1, 32'h40,   0, 32'h999, 0, 0, 0, 0, 32'h40,   1, 1, 32'h100);
        vecs[3]  = mk(1, 32'h40,   0, 32'h0,   0, 0, 1, 0, 32'h40,   1, 0, 32'h100);
        vecs[4]  = mk(1, 32'h40,   0, 32'h0,   0, 0, 0, 0, 32'h40,   1, 0, 32'h100);
        vecs[5]  = mk(1, 32'h40,   1, 32'h104, 0, 0, 0, 0, 32'h40,   1, 0, 32'h100);
        vecs[6]  = mk(0, 32'h0,    0, 32'h0,   0, 0, 0, 0, 32'h40,   1, 0, 32'h104);
        vecs[7]  = mk(1, 32'h40,   1, 32'h104, 0, 0, 0, 0, 32'h40,   1, 0, 32'h104);
        vecs[8]  = mk(1, 32'h40,   1, 32'h104, 0, 0, 0, 0, 32'h40,   1, 1, 32'h104);
        vecs[9]  = mk(1, 32'h40,   1, 32'h104, 0, 0, 0, 0, 32'h40,   1, 1, 32'h104);
        vecs[10] = mk(1, 32'h40,   0, 32'h0,   0, 0, 0, 0, 32'h40,   1, 1, 32'h104);
        vecs[11] = mk(1, 32'h40,   0, 32'h0,   0, 0, 0, 0, 32'h40,   1, 1, 32'h104);
        vecs[12] = mk(1, 32'h40,   1, 32'h300, 0, 1, 1, 0, 32'h40,   1, 0, 32'h104);
        vecs[13] = mk(1, 32'h48,   0, 32'h0,   0, 0, 0, 0, 32'h40,   1, 0, 32'h104);
        vecs[14] = mk(1, 32'h44,   1, 32'h500, 0, 0, 0, 0, 32'h48,   0, 0, 32'h0);
        vecs[15] = mk(1, 32'h80,   1, 32'h200, 1, 0, 0, 0, 32'h44,   1, 1, 32'h500);
        vecs[16] = mk(1, 32'h80,   0, 32'h0,   0, 0, 1, 0, 32'h80,   1, 1, 32'h200);
        vecs[17] = mk(0, 32'h0,    0, 32'h0,   0, 0, 0, 0, 32'h80,   1, 1, 32'h200);
        vecs[18] = mk(0, 32'h0,    0, 32'h0,   0, 0, 0, 0, 32'h40,   0, 0, 32'h0);
        vecs[19] = mk(0, 32'h0,    0, 32'h0,   0, 0, 0, 0, 32'h4080, 0, 0, 32'h0);
        vecs[20] = mk(1, 32'h4080, 1, 32'h600, 0, 0, 0, 0, 32'h80,   1, 1, 32'h200);
        vecs[21] = mk(0, 32'h0,    0, 32'h0,   0, 0, 0, 0, 32'h80,   0, 0, 32'h0);
        vecs[22] = mk(0, 32'h0,    0, 32'h0,   0, 0, 0, 0, 32'h4080, 1, 1, 32'h600);
        vecs[23] = mk(1, 32'h4080, 1, 32'h700, 1, 0, 0, 0, 32'h44,   1, 1, 32'h500);
        vecs[24] = mk(0, 32'h0,    0, 32'h0,   0, 0, 0, 0, 32'h4080, 1, 1, 32'h700);
        vecs[25] = mk(1, 32'h40,   1, 32'h100, 0, 0, 0, 1, 32'h4080, 1, 1, 32'h700);
        vecs[26] = mk(0, 32'h0,    0, 32'h0,   0, 0, 0, 0, 32'h40,   0, 0, 32'h0);
        vecs[27] = mk(0, 32'h0,    0, 32'h0,   0, 0, 0, 0, 32'h44,   0, 0, 32'h0);
        vecs[28] = mk(1, 32'h40,   1, 32'h100, 0, 0, 0, 0, 32'h40,   0, 0, 32'h0);
        vecs[29] = mk(1, 32'h40,   0, 32'h0,   0, 0, 0, 0, 32'h40,   1, 1, 32'h100);
        vecs[30] = mk(0, 32'h0,    0, 32'h0,   0, 0, 0, 0, 32'h43,   1, 0, 32'h100);

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        lookup_pc = 32'h40;
        @(negedge clk);
        check_lookup("reset", 1'b0, 1'b0, 32'h0);
        check("reset_stat_br", stat_branches, 32'd0);
        check("reset_stat_mis", stat_mispredicts, 32'd0);

        // Directed table
        for (int i = 0; i < NVec; i++) begin
            @(posedge clk);
            #1;
            update_valid      = vecs[i].upd;
            update_pc         = vecs[i].pc;
            update_taken      = vecs[i].taken;
            update_target     = vecs[i].tgt;
            update_is_jump    = vecs[i].jump;
            update_is_jalr    = vecs[i].jalr;
            update_mispredict = vecs[i].mis;
            flush             = vecs[i].flush;
            lookup_pc         = vecs[i].lk;
            if (vecs[i].upd && !vecs[i].flush) exp_br++;
            if (vecs[i].upd && vecs[i].mis) exp_mis++;
            @(negedge clk);
            check_lookup($sformatf("v%0d", i), vecs[i].e_hit, vecs[i].e_taken, vecs[i].e_tgt);
        end

        // Statistics after the table
        @(posedge clk);
        #1 idle_inputs();
        @(negedge clk);
        check("tbl_stat_br", stat_branches, StatsEn ? 32'(exp_br) : 32'd0);
        check("tbl_stat_mis", stat_mispredicts, StatsEn ? 32'(exp_mis) : 32'd0);

        // Flush with a concurrent update: stats unchanged, table emptied
        @(posedge clk);
        #1;
        flush = 1'b1; update_valid = 1'b1; update_pc = 32'h40;
        update_taken = 1'b1; update_target = 32'h100;
        @(posedge clk);
        #1 idle_inputs();
        lookup_pc = 32'h40;
        @(negedge clk);
        check_lookup("flush", 1'b0, 1'b0, 32'h0);
        check("flush_stat_br", stat_branches, StatsEn ? 32'(exp_br) : 32'd0);
        check("flush_stat_mis", stat_mispredicts, StatsEn ? 32'(exp_mis) : 32'd0);

        // Re-train 0x44, then reset mid-operation with a concurrent update
        @(posedge clk);
        #1;
        update_valid = 1'b1; update_pc = 32'h44; update_taken = 1'b1;
        update_target = 32'h500; update_mispredict = 1'b1; lookup_pc = 32'h44;
        @(posedge clk);
        #1 idle_inputs();
        @(negedge clk);
        check_lookup("retrain", 1'b1, 1'b1, 32'h500);
        @(posedge clk);
        #1;
        rst = 1'b1; update_valid = 1'b1; update_pc = 32'h48; update_taken = 1'b1;
        update_target = 32'h900; update_mispredict = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        idle_inputs();
        lookup_pc = 32'h44;
        @(negedge clk);
        check_lookup("rst_mid_44", 1'b0, 1'b0, 32'h0);
        check("rst_stat_br", stat_branches, 32'd0);
        check("rst_stat_mis", stat_mispredicts, 32'd0);
        lookup_pc = 32'h48;
        #1;
        check_lookup("rst_mid_48", 1'b0, 1'b0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
